rename_reg_file: RTL
====================

Name: rename_reg_file

Overview:
- Superscalar successor to the single-issue RF: architectural register values plus RoB-tag dependency table.
- Provides ISSUE_W rename slots per cycle, each with two source lookups and intra-bundle forwarding.
- Provides COMMIT_W RoB write-back ports with same-cycle bypass.
- Holds a circular pool of branch checkpoints, so a mispredict restores the table selectively instead of flushing it.
- Sits between Dispatcher (rename) and RoB (commit, recover, flush).

Parameters:
- RoB_WIDTH, 3, RoB index bits; tag is RoB_WIDTH+1 bits, MSB set = no dependency.
- REG_WIDTH, 5, architectural register index bits.
- ISSUE_W, 2, rename slots per cycle.
- COMMIT_W, 2, commit ports per cycle.
- CKPT_WIDTH, 2, checkpoint index bits; NUM_CKPT = 1<<CKPT_WIDTH.

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  reset. One clock; reset is synchronous and active-high.
- rdy_in  in  1  0 = freeze all state; combinational outputs stay valid.
- flush_signal  in  1  full flush from RoB.
- commit_en  in  COMMIT_W  per-port commit valid; higher port index = younger.
- commit_reg  in  COMMIT_W*REG_WIDTH  destination register per port.
- commit_idx  in  COMMIT_W*RoB_WIDTH  RoB index per port.
- commit_data  in  COMMIT_W*32  committed value per port.
- rs1, rs2  in  ISSUE_W*REG_WIDTH each  source registers; 0 = unused.
- Qj, Qk  out  ISSUE_W*(RoB_WIDTH+1) each  source tags.
- Vj, Vk  out  ISSUE_W*32 each  source values; 0 when a tag is pending.
- rename_en  in  ISSUE_W  slot valid; slot 0 is oldest.
- rename_tag  in  ISSUE_W*RoB_WIDTH  RoB entry per slot.
- rename_rd  in  ISSUE_W*REG_WIDTH  destination register per slot.
- ckpt_en  in  1  take a checkpoint this cycle.
- ckpt_slot  in  log2(ISSUE_W) (min 1)  branch slot; the snapshot includes renames of slots 0..ckpt_slot.
- ckpt_id  out  CKPT_WIDTH  id allocated if ckpt_en is accepted this cycle.
- ckpt_full  out  1  no free checkpoint.
- ckpt_free  in  1  release the oldest checkpoint (branch resolved correct).
- recover_en  in  1  mispredict.
- recover_id  in  CKPT_WIDTH  checkpoint to restore.

Behaviour:
- Reset: all registers 0, all tags NON_DEP, head=tail=0, count=0. Outputs: ckpt_full=0, ckpt_id=0.
- Lookup is combinational. Sources resolve in this order, first match wins:
  - rs=0 or flush_signal → NON_DEP, value 0.
  - Older slot j<i with rename_en[j] and rename_rd[j]==rs (youngest such j) → tag {0,rename_tag[j]}, V=0.
  - Table tag matches an active commit_idx → NON_DEP, V = that commit_data (youngest matching port).
  - Otherwise → table tag; V = register value if NON_DEP, else 0.
- Table update at the clock edge, when rdy_in=1 and none of rst_in, flush_signal or recover_en is active:
  - Each commit with reg≠0 writes the register file; youngest port wins for equal regs.
  - The tag clears only if it still equals commit_idx.
  - Renames then overwrite tags (rd≠0), youngest slot wins. A rename beats a commit clear to the same reg.
- Commits also clear matching tags inside every valid checkpoint in the same cycle.
- Checkpoint accept:
  - Accepted when ckpt_en and the pre-cycle count < NUM_CKPT.
  - Stores the post-commit table with renames of slots 0..ckpt_slot only, into entry tail.
  - ckpt_id = tail; tail++ (wraps); count++.
  - ckpt_en while full is ignored; the Dispatcher must stall on ckpt_full.
- ckpt_free: head++ and count--; ignored when empty. Simultaneous free and accept leave count unchanged.
- recover_en:
  - Table = snapshot[recover_id] with this cycle's commits applied; register values are written normally.
  - This cycle's renames and ckpt_en are dropped.
  - tail = recover_id; count = recover_id - head (mod NUM_CKPT), which discards recover_id and all younger checkpoints.
  - A simultaneous ckpt_free is still honoured.
- Priority: rst_in > !rdy_in > flush_signal > recover_en > normal.
- flush_signal: all tags NON_DEP, checkpoints emptied (head=tail, count=0), registers keep their values; commits that cycle are dropped.
- rdy_in=0: no state change.
- Pointer arithmetic is modulo NUM_CKPT; count is CKPT_WIDTH+1 bits.

Decomposition:
- Shared package: NON_DEP, tag width, flattened-bus slice helpers, reg-0 constant.
- Sub-module rename_ckpt_pool: snapshot storage, head/tail/count, commit clearing of stored tags.
- Lookup/forwarding and table update stay in the top module.

Test Plan:
- Bundle with slot0 rd=x5 tag 3, slot1 rs1=x5 → Qj[1]=3, Vj[1]=0; next cycle the table shows x5 tag 3.
- x7 tag 2; commit port0 idx 2 data 0x55 while slot0 reads rs2=x7 → Qk=NON_DEP (8), Vk=0x55.
- Same-cycle commit to x7 idx 2 and rename x7 tag 4 → next cycle x7 tag 4, reg 0x55.
- Checkpoint taken with x3 tag 1, then rename x3 tag 5, commit idx 1 data 9, then recover → x3 NON_DEP, value 9.
- Take 4 checkpoints → ckpt_full=1; 5th ckpt_en ignored; ckpt_free → full=0; recover_id=head+1 → count=1.
- Flush with pending tags and 2 checkpoints → all Q=NON_DEP, count=0, register values intact.

Source files
------------

// File: rtl/rename_reg_file_pkg.sv
// Shared constants and helpers for the superscalar rename register file.
// Defaults give a 3-bit RoB index, 32 registers, 2-wide issue/commit, 4 checkpoints.
package rename_reg_file_pkg;

  localparam int DEF_ROB_W    = 3;
  localparam int DEF_REG_W    = 5;
  localparam int DEF_ISSUE_W  = 2;
  localparam int DEF_COMMIT_W = 2;
  localparam int DEF_CKPT_W   = 2;

  localparam int REG_ZERO = 0;

  // Tag width is the RoB index plus one "no dependency" flag bit
  function automatic int tag_w(input int rob_w);
    return rob_w + 1;
  endfunction

  function automatic logic [31:0] non_dep(input int rob_w);
    return 32'(1) << rob_w;
  endfunction

  function automatic int slot_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rename_ckpt_pool.sv
// Circular pool of rename-table snapshots taken at branches.
// Stored tags are cleared by commits so a restore never resurrects a retired producer.
module rename_ckpt_pool
  import rename_reg_file_pkg::*;
#(
  parameter int RoB_WIDTH  = DEF_ROB_W,
  parameter int REG_WIDTH  = DEF_REG_W,
  parameter int COMMIT_W   = DEF_COMMIT_W,
  parameter int CKPT_WIDTH = DEF_CKPT_W
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               rdy,
  input  logic                               flush,
  input  logic                               recover_en,
  input  logic [CKPT_WIDTH-1:0]              recover_id,
  input  logic                               ckpt_en,
  input  logic                               ckpt_free,
  input  logic [(1<<REG_WIDTH)-1:0][RoB_WIDTH:0] snap_in,
  input  logic [COMMIT_W-1:0]                commit_en,
  input  logic [COMMIT_W*RoB_WIDTH-1:0]      commit_idx,
  output logic [(1<<REG_WIDTH)-1:0][RoB_WIDTH:0] restore,
  output logic [CKPT_WIDTH-1:0]              ckpt_id,
  output logic                               ckpt_full
);

  localparam int NUM_CKPT = 1 << CKPT_WIDTH;
  localparam int NREG     = 1 << REG_WIDTH;
  localparam int TAG_W    = tag_w(RoB_WIDTH);
  localparam logic [TAG_W-1:0] NON_DEP = TAG_W'(non_dep(RoB_WIDTH));
  localparam logic [CKPT_WIDTH:0] FULL = (CKPT_WIDTH+1)'(NUM_CKPT);

  logic [NUM_CKPT-1:0][NREG-1:0][TAG_W-1:0] snap_q;
  logic [NUM_CKPT-1:0][NREG-1:0][TAG_W-1:0] cleared;
  logic [CKPT_WIDTH-1:0] head_q;
  logic [CKPT_WIDTH-1:0] tail_q;
  logic [CKPT_WIDTH-1:0] span;
  logic [CKPT_WIDTH:0]   count_q;
  logic                  accept;
  logic                  free_ok;

  always_comb begin
    cleared = snap_q;
    for (int e = 0; e < NUM_CKPT; e++) begin
      for (int r = 0; r < NREG; r++) begin
        for (int p = 0; p < COMMIT_W; p++) begin
          if (commit_en[p] &&
              snap_q[e][r] == {1'b0, commit_idx[p*RoB_WIDTH +: RoB_WIDTH]})
            cleared[e][r] = NON_DEP;
        end
      end
    end
  end

  // On recovery the surviving range ends just before recover_id
  assign span      = recover_id - head_q;
  assign accept    = ckpt_en && !recover_en && (count_q < FULL);
  assign free_ok   = ckpt_free &&
                     (recover_en ? (span != '0) : (count_q != '0));
  assign restore   = cleared[recover_id];
  assign ckpt_id   = tail_q;
  assign ckpt_full = (count_q == FULL);

  always_ff @(posedge clk) begin
    if (rst) begin
      snap_q  <= {(NUM_CKPT*NREG){NON_DEP}};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (rdy) begin
      if (flush) begin
        head_q  <= tail_q;
        count_q <= '0;
      end else begin
        snap_q <= cleared;
        if (accept)
          snap_q[tail_q] <= snap_in;
        head_q <= head_q + CKPT_WIDTH'(free_ok);
        if (recover_en) begin
          tail_q  <= recover_id;
          count_q <= {1'b0, span} - (CKPT_WIDTH+1)'(free_ok);
        end else begin
          tail_q  <= tail_q + CKPT_WIDTH'(accept);
          count_q <= count_q + (CKPT_WIDTH+1)'(accept)
                     - (CKPT_WIDTH+1)'(free_ok);
        end
      end
    end
  end

endmodule

// File: rtl/rename_reg_file.sv
// Superscalar register file with RoB-tag rename table, intra-bundle
// forwarding, commit bypass and branch checkpoint recovery.
module rename_reg_file
  import rename_reg_file_pkg::*;
#(
  parameter int RoB_WIDTH  = DEF_ROB_W,
  parameter int REG_WIDTH  = DEF_REG_W,
  parameter int ISSUE_W    = DEF_ISSUE_W,
  parameter int COMMIT_W   = DEF_COMMIT_W,
  parameter int CKPT_WIDTH = DEF_CKPT_W
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              rdy_in,
  input  logic                              flush_signal,
  input  logic [COMMIT_W-1:0]               commit_en,
  input  logic [COMMIT_W*REG_WIDTH-1:0]     commit_reg,
  input  logic [COMMIT_W*RoB_WIDTH-1:0]     commit_idx,
  input  logic [COMMIT_W*32-1:0]            commit_data,
  input  logic [ISSUE_W*REG_WIDTH-1:0]      rs1,
  input  logic [ISSUE_W*REG_WIDTH-1:0]      rs2,
  output logic [ISSUE_W*(RoB_WIDTH+1)-1:0]  Qj,
  output logic [ISSUE_W*(RoB_WIDTH+1)-1:0]  Qk,
  output logic [ISSUE_W*32-1:0]             Vj,
  output logic [ISSUE_W*32-1:0]             Vk,
  input  logic [ISSUE_W-1:0]                rename_en,
  input  logic [ISSUE_W*RoB_WIDTH-1:0]      rename_tag,
  input  logic [ISSUE_W*REG_WIDTH-1:0]      rename_rd,
  input  logic                              ckpt_en,
  input  logic [slot_w(ISSUE_W)-1:0]        ckpt_slot,
  output logic [CKPT_WIDTH-1:0]             ckpt_id,
  output logic                              ckpt_full,
  input  logic                              ckpt_free,
  input  logic                              recover_en,
  input  logic [CKPT_WIDTH-1:0]             recover_id
);

  localparam int NREG   = 1 << REG_WIDTH;
  localparam int TAG_W  = tag_w(RoB_WIDTH);
  localparam int SLOT_W = slot_w(ISSUE_W);
  localparam logic [TAG_W-1:0] NON_DEP = TAG_W'(non_dep(RoB_WIDTH));
  localparam logic [REG_WIDTH-1:0] R0 = REG_WIDTH'(REG_ZERO);

  logic [NREG-1:0][TAG_W-1:0] tag_q;
  logic [NREG-1:0][TAG_W-1:0] tag_c;
  logic [NREG-1:0][TAG_W-1:0] tag_n;
  logic [NREG-1:0][TAG_W-1:0] snap_n;
  logic [NREG-1:0][TAG_W-1:0] restore;
  logic [NREG-1:0][31:0]      reg_q;
  logic [NREG-1:0][31:0]      reg_n;

  logic [ISSUE_W-1:0][1:0][TAG_W-1:0] q_a;
  logic [ISSUE_W-1:0][1:0][31:0]      v_a;
  logic [REG_WIDTH-1:0] r;
  logic [TAG_W-1:0]     t;
  logic [31:0]          v;
  logic [REG_WIDTH-1:0] cr;
  logic [REG_WIDTH-1:0] rd;

  // Later loop iterations override earlier ones, so youngest match wins
  always_comb begin
    q_a = '0;
    v_a = '0;
    r   = '0;
    t   = '0;
    v   = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      for (int s = 0; s < 2; s++) begin
        r = (s == 0) ? rs1[i*REG_WIDTH +: REG_WIDTH]
                     : rs2[i*REG_WIDTH +: REG_WIDTH];
        t = tag_q[r];
        v = (t == NON_DEP) ? reg_q[r] : '0;
        for (int p = 0; p < COMMIT_W; p++) begin
          if (commit_en[p] &&
              tag_q[r] == {1'b0, commit_idx[p*RoB_WIDTH +: RoB_WIDTH]}) begin
            t = NON_DEP;
            v = commit_data[p*32 +: 32];
          end
        end
        for (int j = 0; j < i; j++) begin
          if (rename_en[j] && rename_rd[j*REG_WIDTH +: REG_WIDTH] == r) begin
            t = {1'b0, rename_tag[j*RoB_WIDTH +: RoB_WIDTH]};
            v = '0;
          end
        end
        if (r == R0 || flush_signal) begin
          t = NON_DEP;
          v = '0;
        end
        q_a[i][s] = t;
        v_a[i][s] = v;
      end
    end
  end

  always_comb begin
    Qj = '0;
    Qk = '0;
    Vj = '0;
    Vk = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      Qj[i*TAG_W +: TAG_W] = q_a[i][0];
      Qk[i*TAG_W +: TAG_W] = q_a[i][1];
      Vj[i*32 +: 32]       = v_a[i][0];
      Vk[i*32 +: 32]       = v_a[i][1];
    end
  end

  always_comb begin
    tag_c = tag_q;
    reg_n = reg_q;
    cr    = '0;
    rd    = '0;
    for (int p = 0; p < COMMIT_W; p++) begin
      cr = commit_reg[p*REG_WIDTH +: REG_WIDTH];
      if (commit_en[p] && cr != R0) begin
        reg_n[cr] = commit_data[p*32 +: 32];
        if (tag_q[cr] == {1'b0, commit_idx[p*RoB_WIDTH +: RoB_WIDTH]})
          tag_c[cr] = NON_DEP;
      end
    end
    tag_n  = tag_c;
    snap_n = tag_c;
    for (int j = 0; j < ISSUE_W; j++) begin
      rd = rename_rd[j*REG_WIDTH +: REG_WIDTH];
      if (rename_en[j] && rd != R0) begin
        tag_n[rd] = {1'b0, rename_tag[j*RoB_WIDTH +: RoB_WIDTH]};
        if (SLOT_W'(j) <= ckpt_slot)
          snap_n[rd] = {1'b0, rename_tag[j*RoB_WIDTH +: RoB_WIDTH]};
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      tag_q <= {NREG{NON_DEP}};
      reg_q <= '0;
    end else if (rdy_in) begin
      if (flush_signal) begin
        tag_q <= {NREG{NON_DEP}};
      end else begin
        reg_q <= reg_n;
        tag_q <= recover_en ? restore : tag_n;
      end
    end
  end

  rename_ckpt_pool #(
    .RoB_WIDTH  (RoB_WIDTH),
    .REG_WIDTH  (REG_WIDTH),
    .COMMIT_W   (COMMIT_W),
    .CKPT_WIDTH (CKPT_WIDTH)
  ) u_pool (
    .clk        (clk_in),
    .rst        (rst_in),
    .rdy        (rdy_in),
    .flush      (flush_signal),
    .recover_en (recover_en),
    .recover_id (recover_id),
    .ckpt_en    (ckpt_en),
    .ckpt_free  (ckpt_free),
    .snap_in    (snap_n),
    .commit_en  (commit_en),
    .commit_idx (commit_idx),
    .restore    (restore),
    .ckpt_id    (ckpt_id),
    .ckpt_full  (ckpt_full)
  );

endmodule
